// File: rtl/axi_read_burst_gen_if.sv
// rtl/axi_read_burst_gen_if.sv - AXI4 bus interface carrying all five channels
interface axi_bus_t #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_read_burst_gen.sv
// rtl/axi_read_burst_gen.sv - AXI4 read master splitting a linear request into INCR bursts
module axi_read_burst_gen #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_BURST_LEN   = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_beats,
    axi_bus_t.master              m_axi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err
);
    localparam int BPB       = DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BPB);
    localparam int OW        = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [31:0]           ar_rem_q, ar_rem_d;
    logic [31:0]           rx_rem_q, rx_rem_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  err_q, err_d;
    logic                  ar_hs, r_hs, rlast_hs;
    logic [8:0]            burst_now;
    logic                  unused_inputs;

    // Beats that fit before the next 4 KB page, the burst cap and the remaining count.
    function automatic logic [8:0] burst_len(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [31:0] rem);
        logic [12:0] page_beats;
        logic [31:0] len;
        page_beats = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE_LOG2;
        len = rem;
        if (len > 32'(MAX_BURST_LEN)) len = 32'(MAX_BURST_LEN);
        if (len > {19'd0, page_beats}) len = {19'd0, page_beats};
        return len[8:0];
    endfunction

    always_comb begin
        ar_hs     = arvalid_q && m_axi.arready;
        r_hs      = m_axi.rvalid && out_ready;
        rlast_hs  = r_hs && m_axi.rlast;
        burst_now = {1'b0, arlen_q} + 9'd1;

        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        ar_rem_d   = ar_rem_q;
        rx_rem_d   = rx_rem_q;
        outst_d    = outst_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        err_d      = err_q;

        if (r_hs && rx_rem_q != 32'd0) rx_rem_d = rx_rem_q - 32'd1;
        if (r_hs && m_axi.rresp != 2'b00) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cur_addr_d = req_addr;
                    ar_rem_d   = req_beats;
                    rx_rem_d   = req_beats;
                    err_d      = 1'b0;
                    state_d    = (req_beats == 32'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (ar_hs) begin
                    cur_addr_d = cur_addr_q + (ADDR_WIDTH'(burst_now) << SIZE_LOG2);
                    ar_rem_d   = ar_rem_q - 32'(burst_now);
                    if (ar_rem_d == 32'd0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rx_rem_q == 32'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case ({ar_hs, rlast_hs})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   if (outst_q != '0) outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        // A pending AR is frozen; otherwise the next one is prepared from post-update state.
        if (!(arvalid_q && !m_axi.arready)) begin
            arvalid_d = (state_d == ISSUE) && (ar_rem_d != 32'd0) &&
                        (outst_d < OW'(MAX_OUTSTANDING));
            araddr_d  = cur_addr_d;
            arlen_d   = 8'(burst_len(cur_addr_d, ar_rem_d) - 9'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            ar_rem_q   <= '0;
            rx_rem_q   <= '0;
            outst_q    <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            ar_rem_q   <= ar_rem_d;
            rx_rem_q   <= rx_rem_d;
            outst_q    <= outst_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'(SIZE_LOG2);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = arvalid_q;

    assign out_valid    = m_axi.rvalid;
    assign out_data     = m_axi.rdata;
    assign out_last     = m_axi.rvalid && (rx_rem_q == 32'd1);
    assign m_axi.rready = out_ready;

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = '0;
    assign m_axi.awlen   = '0;
    assign m_axi.awsize  = '0;
    assign m_axi.awburst = '0;
    assign m_axi.awvalid = 1'b0;
    assign m_axi.wdata   = '0;
    assign m_axi.wstrb   = '0;
    assign m_axi.wlast   = 1'b0;
    assign m_axi.wvalid  = 1'b0;
    assign m_axi.bready  = 1'b1;

    assign unused_inputs = ^{m_axi.awready, m_axi.wready, m_axi.bid, m_axi.bresp,
                             m_axi.bvalid, m_axi.rid};
endmodule

// File: tb/tb_axi_read_burst_gen.sv
// tb/tb_axi_read_burst_gen.sv - randomized model-based bench for axi_read_burst_gen
module tb_axi_read_burst_gen;
    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int MBL = 64;
    localparam int MO  = 4;
    localparam int BPB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_beats;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    axi_bus_t #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    axi_read_burst_gen #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_beats(req_beats), .m_axi(axi),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 64; i++) v[i*64 +: 64] = {a[31:0], ~a[31:0]} ^ 64'(i);
        return v;
    endfunction

    // Reference model and observation logs
    logic [AW-1:0] exp_ar_addr[$];
    int            exp_ar_len[$];
    logic [AW-1:0] exp_base;
    int            exp_beats = 0;
    int            exp_idx = 0;
    logic          err_model = 1'b0;
    int            outst_model = 0;
    logic          prev_pend = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_len;
    int            ncyc = 0;
    int            acc_lbl = 0;
    logic [AW-1:0] obs_addr[$];
    int            obs_len[$];
    int            obs_lbl[$];
    int            rlast_lbls[$];
    int            last_cnt = 0;
    int            last_idx = -1;

    // Slave model state and handshake flags handed from monitor to slave
    logic [AW-1:0] s_addr[$];
    int            s_len[$];
    int            s_beat = 0;
    int            rcount = 0;
    int            arready_mode = 0;
    int            r_mode = 1;
    int            or_mode = 0;
    int            err_beat = -1;
    logic          r_hs_n = 1'b0;
    logic          flush_n = 1'b0;
    logic          new_req_n = 1'b0;

    initial begin : monitor
        logic [AW-1:0] a;
        int rem, l, pg;
        forever begin
            @(negedge clk);
            ncyc++;
            r_hs_n = 1'b0;
            new_req_n = 1'b0;
            flush_n = 1'b0;
            if (rst) begin
                exp_ar_addr.delete();
                exp_ar_len.delete();
                exp_beats = 0;
                exp_idx = 0;
                err_model = 1'b0;
                outst_model = 0;
                prev_pend = 1'b0;
                flush_n = 1'b1;
            end else begin
                chk("out_valid_pass", out_valid, axi.rvalid);
                chk("rready_pass", axi.rready, out_ready);
                if (prev_pend) begin
                    chk("ar_hold_valid", axi.arvalid, 1);
                    chk("ar_hold_addr", axi.araddr, prev_addr);
                    chk("ar_hold_len", axi.arlen, prev_len);
                end
                if (axi.arvalid && axi.arready) begin
                    chk("arsize", axi.arsize, 6);
                    chk("arburst", axi.arburst, 1);
                    chk("arid", axi.arid, 0);
                    if (exp_ar_addr.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ar: got addr %0h expected none", axi.araddr);
                    end else begin
                        chk("ar_addr", axi.araddr, exp_ar_addr.pop_front());
                        chk("ar_len", axi.arlen, exp_ar_len.pop_front());
                    end
                    obs_addr.push_back(axi.araddr);
                    obs_len.push_back(int'(axi.arlen));
                    obs_lbl.push_back(ncyc);
                    s_addr.push_back(axi.araddr);
                    s_len.push_back(int'(axi.arlen));
                    outst_model++;
                end
                prev_pend = axi.arvalid && !axi.arready;
                prev_addr = axi.araddr;
                prev_len  = axi.arlen;
                chk("err", err, err_model);
                if (exp_idx < exp_beats) chk("busy", busy, 1);
                if (out_valid) chk("out_last", out_last, (exp_idx == exp_beats - 1));
                if (axi.rvalid && out_ready) begin
                    r_hs_n = 1'b1;
                    if (exp_idx >= exp_beats) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_beat: got beat %0d expected at most %0d", exp_idx, exp_beats);
                    end else begin
                        chk_wide("beat_data", out_data, pat(exp_base + 64'(exp_idx) * 64'(BPB)));
                    end
                    if (out_last) begin
                        last_cnt++;
                        last_idx = exp_idx;
                    end
                    exp_idx++;
                    if (axi.rresp != 2'b00) err_model = 1'b1;
                    if (axi.rlast) begin
                        outst_model--;
                        rlast_lbls.push_back(ncyc);
                    end
                end
                chk("outstanding_limit", (outst_model <= MO), 1);
                if (req_valid && req_ready) begin
                    acc_lbl = ncyc;
                    new_req_n = 1'b1;
                    err_model = 1'b0;
                    exp_base = req_addr;
                    exp_beats = int'(req_beats);
                    exp_idx = 0;
                    exp_ar_addr.delete();
                    exp_ar_len.delete();
                    a = req_addr;
                    rem = int'(req_beats);
                    while (rem > 0) begin
                        l = (rem > MBL) ? MBL : rem;
                        pg = (4096 - int'(a % 4096)) / BPB;
                        if (l > pg) l = pg;
                        exp_ar_addr.push_back(a);
                        exp_ar_len.push_back(l - 1);
                        a = a + 64'(l * BPB);
                        rem = rem - l;
                    end
                end
            end
        end
    end

    initial begin : slave
        axi.arready = 1'b0;
        axi.rvalid = 1'b0;
        axi.rdata = '0;
        axi.rresp = 2'b00;
        axi.rlast = 1'b0;
        axi.rid = '0;
        axi.awready = 1'b0;
        axi.wready = 1'b0;
        axi.bid = '0;
        axi.bresp = 2'b00;
        axi.bvalid = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (flush_n) begin
                s_addr.delete();
                s_len.delete();
                s_beat = 0;
                rcount = 0;
                axi.rvalid = 1'b0;
            end else begin
                if (new_req_n) rcount = 0;
                if (r_hs_n) begin
                    s_beat++;
                    rcount++;
                    if (s_beat > s_len[0]) begin
                        void'(s_addr.pop_front());
                        void'(s_len.pop_front());
                        s_beat = 0;
                    end
                end
                if (!(axi.rvalid && !r_hs_n))
                    axi.rvalid = (s_addr.size() > 0) &&
                                 (r_mode == 1 || (r_mode == 2 && $urandom_range(0, 2) != 0));
            end
            if (axi.rvalid) begin
                axi.rdata = pat(s_addr[0] + 64'(s_beat) * 64'(BPB));
                axi.rlast = (s_beat == s_len[0]);
                axi.rresp = (rcount == err_beat) ? 2'b10 : 2'b00;
            end else begin
                axi.rdata = '0;
                axi.rlast = 1'b0;
                axi.rresp = 2'b00;
            end
            axi.arready = (arready_mode == 0) ? 1'b1 :
                          (arready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (or_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic timeout_fail(input string name, input int limit);
        checks++;
        failures++;
        $display("FAIL %s: got timeout after %0d cycles expected completion", name, limit);
    endtask

    task automatic do_req(input logic [AW-1:0] a, input int b);
        int n = 0;
        obs_addr.delete();
        obs_len.delete();
        obs_lbl.delete();
        rlast_lbls.delete();
        last_cnt = 0;
        last_idx = -1;
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout_fail("req_ready_wait", n);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr = a;
        req_beats = 32'(b);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready && exp_idx >= exp_beats && exp_ar_addr.size() == 0) && n < 8000);
        if (n >= 8000) timeout_fail(name, n);
    endtask

    initial begin : stimulus
        logic [AW-1:0] ra;
        int rb;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_beats = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        do_req(64'h1000, 4);
        wait_done("single");
        chk("single_n_ar", obs_addr.size(), 1);
        chk("single_addr", obs_addr[0], 64'h1000);
        chk("single_len", obs_len[0], 3);
        chk("single_ar_latency", obs_lbl[0], acc_lbl + 1);
        chk("single_last_cnt", last_cnt, 1);
        chk("single_last_idx", last_idx, 3);

        do_req(64'h0FC0, 3);
        wait_done("split");
        chk("split_n_ar", obs_addr.size(), 2);
        chk("split_addr0", obs_addr[0], 64'h0FC0);
        chk("split_len0", obs_len[0], 0);
        chk("split_addr1", obs_addr[1], 64'h1000);
        chk("split_len1", obs_len[1], 1);
        chk("split_last_idx", last_idx, 2);

        do_req(64'h0, 200);
        wait_done("long");
        chk("long_n_ar", obs_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("long_addr", obs_addr[i], 64'(i) * 64'h1000);
            chk("long_len", obs_len[i], (i == 3) ? 7 : 63);
            chk("long_issue_cycle", obs_lbl[i], acc_lbl + 1 + i);
        end

        r_mode = 0;
        do_req(64'h0, 600);
        repeat (20) @(negedge clk);
        chk("limit_n_ar", obs_addr.size(), MO);
        chk("limit_arvalid_low", axi.arvalid, 0);
        r_mode = 1;
        begin
            int n = 0;
            while (obs_addr.size() <= MO && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        if (obs_addr.size() > MO && rlast_lbls.size() > 0)
            chk("limit_resume_cycle", obs_lbl[MO], rlast_lbls[0] + 1);
        else
            timeout_fail("limit_resume", 1000);
        wait_done("limit");

        arready_mode = 1;
        r_mode = 2;
        or_mode = 1;
        for (int t = 0; t < 6; t++) begin
            err_beat = (t == 0) ? 4 : -1;
            ra = (64'($urandom_range(0, 255)) << 12) | (64'($urandom_range(0, 63)) << 6);
            rb = (t == 0) ? int'($urandom_range(40, 120)) : int'($urandom_range(0, 150));
            do_req(ra, rb);
            if (t == 1) begin
                @(negedge clk);
                chk("err_cleared", err, 0);
            end
            wait_done("random");
            if (t == 0) chk("err_sticky", err, 1);
            if (t == 0) chk("rand_last_cnt", last_cnt, 1);
        end
        arready_mode = 0;
        r_mode = 1;
        or_mode = 0;
        err_beat = -1;

        do_req(64'h2000, 0);
        @(negedge clk);
        chk("zero_ready_n1", req_ready, 0);
        @(negedge clk);
        chk("zero_ready_n2", req_ready, 1);
        chk("zero_n_ar", obs_addr.size(), 0);

        err_beat = 0;
        do_req(64'h0, 600);
        begin
            int n = 0;
            while (!err && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (!err) timeout_fail("reset_err_wait", n);
            arready_mode = 2;
            n = 0;
            while (!axi.arvalid && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!axi.arvalid) timeout_fail("reset_arvalid_wait", n);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        arready_mode = 0;
        err_beat = -1;
        @(negedge clk);
        chk("midrst_arvalid", axi.arvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        chk("midrst_req_ready_after", req_ready, 1);

        do_req(64'h3FC0, 5);
        wait_done("post_reset");
        chk("post_reset_n_ar", obs_addr.size(), 2);
        chk("post_reset_last_idx", last_idx, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
